// File: rtl/intc8.sv
// Eight-source priority interrupt controller: synchronises irq lines, latches
// rising edges as pending, and runs the intr/inta handshake with nesting.
module intc8 #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter logic [7:0]  MASK_RST  = 8'hFF
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [7:0]  irq,
  input  logic        inta,
  output logic        intr,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  input  logic        Wmem,
  output logic [31:0] Rdata,
  output logic        hit
);

  localparam int unsigned NSRC = 8;
  localparam int unsigned IDW  = 3;

  localparam logic [2:0] OFF_PEND = 3'd0;
  localparam logic [2:0] OFF_MASK = 3'd1;
  localparam logic [2:0] OFF_ISR  = 3'd2;
  localparam logic [2:0] OFF_VEC  = 3'd3;
  localparam logic [2:0] OFF_EOI  = 3'd4;

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t          state, state_n;
  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] pend, pend_n;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] isr, isr_n;
  logic            vec_valid;
  logic [IDW-1:0]  vec_id;

  logic [NSRC-1:0] rise, cand;
  logic [3:0]      cand_low, isr_low;
  logic [IDW-1:0]  top;
  logic            eligible, wr, ack, take;
  logic [2:0]      sel;

  // Lowest set index (highest priority); NSRC when the vector is empty.
  function automatic logic [3:0] lowest(input logic [NSRC-1:0] v);
    lowest = 4'(NSRC);
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = 4'(i);
    end
  endfunction

  assign hit      = (Addr[31:5] == BASE_ADDR[31:5]);
  assign sel      = Addr[4:2];
  assign wr       = Wmem & hit;
  assign rise     = s2 & ~s3;
  assign cand     = pend & ~mask;
  assign cand_low = lowest(cand);
  assign isr_low  = lowest(isr);
  assign top      = cand_low[IDW-1:0];
  assign eligible = (cand != '0) && (cand_low < isr_low);
  assign ack      = (state == REQ) && inta;
  assign take     = ack && eligible;

  logic unused_bits;
  assign unused_bits = ^{Addr[1:0], Wdata[31:NSRC]};

  // Edge synchroniser plus delay flop for rise detection.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending: W1C and acknowledge clear first, so a same-cycle rise wins.
  always_comb begin
    pend_n = pend;
    if (wr && sel == OFF_PEND) pend_n = pend_n & ~Wdata[NSRC-1:0];
    if (take) pend_n[top] = 1'b0;
    pend_n = pend_n | rise;
  end

  // In-service: EOI retires the lowest set bit of the current ISR.
  always_comb begin
    isr_n = isr;
    if (wr && sel == OFF_EOI && isr != '0) isr_n[isr_low[IDW-1:0]] = 1'b0;
    if (take) isr_n[top] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      pend      <= '0;
      mask      <= MASK_RST;
      isr       <= '0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
    end else begin
      pend <= pend_n;
      isr  <= isr_n;
      if (wr && sel == OFF_MASK) mask <= Wdata[NSRC-1:0];
      if (ack) begin
        vec_valid <= eligible;
        if (eligible) vec_id <= top;
      end
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state <= IDLE;
      intr  <= 1'b0;
    end else begin
      state <= state_n;
      intr  <= (state_n == REQ);
    end
  end

  // ACK always returns to IDLE so intr stays low two cycles after an acknowledge.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (eligible) state_n = REQ;
      REQ:     if (inta) state_n = ACK;
               else if (!eligible) state_n = IDLE;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    Rdata = '0;
    case (sel)
      OFF_PEND: Rdata = 32'(pend);
      OFF_MASK: Rdata = 32'(mask);
      OFF_ISR:  Rdata = 32'(isr);
      OFF_VEC:  Rdata = {23'b0, vec_valid, 5'b0, vec_id};
      default:  Rdata = '0;
    endcase
  end

endmodule
